matmul_seq_engine: RTL

MATMUL_SEQ_ENGINE -- requirements
Module: matmul_seq_engine

---
 rtl/matmul_seq_engine.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/matmul_seq_engine.sv
// rtl/matmul_seq_engine.sv - sequential signed matrix multiply engine with result scratchpads
//
// Loads A (NxK) then B (KxM) one row per handshake, then streams C = A*B one
// element per handshake in row-major order. Each element can be accumulated
// onto the matching entry of a selected scratchpad. Every accepted element is
// written back to that scratchpad.
//
// Ports:
//   clk_i, rst_i                                   clock, synchronous active-high reset
//   start_i                                        begin an operation (honoured in IDLE only)
//   n_dim_i, k_dim_i, m_dim_i                      dimensions minus one (A is NxK, B is KxM)
//   bias_i, sp_sel_i                               accumulate enable, target scratchpad
//   row_valid_i, row_ready_o, row_data_i           operand row load handshake
//   c_valid_o, c_ready_i, c_data_o, c_row_o, c_col_o   result element stream
//   busy_o, done_o, ovf_o                          status: busy, completion pulse, sticky overflow

module matmul_seq_engine #(
    parameter int DATA_WIDTH  = 16,
    parameter int BUS_WIDTH   = 64,
    parameter int SP_NTARGETS = 4,
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int DIM_W      = $clog2(MAX_DIM),
    localparam int SEL_W      = $clog2(SP_NTARGETS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [DIM_W-1:0]     n_dim_i,
    input  logic [DIM_W-1:0]     k_dim_i,
    input  logic [DIM_W-1:0]     m_dim_i,
    input  logic                 bias_i,
    input  logic [SEL_W-1:0]     sp_sel_i,
    input  logic                 row_valid_i,
    output logic                 row_ready_o,
    input  logic [BUS_WIDTH-1:0] row_data_i,
    output logic                 c_valid_o,
    input  logic                 c_ready_i,
    output logic [BUS_WIDTH-1:0] c_data_o,
    output logic [DIM_W-1:0]     c_row_o,
    output logic [DIM_W-1:0]     c_col_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ovf_o
);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, DONE} stateType;

    stateType             state;
    logic [DIM_W-1:0]     rowIdx;
    logic [DIM_W-1:0]     nDim;
    logic [DIM_W-1:0]     kDim;
    logic [DIM_W-1:0]     mDim;
    logic                 biasEn;
    logic [SEL_W-1:0]     spSel;

    logic [DATA_WIDTH-1:0] aMat  [MAX_DIM][MAX_DIM];
    logic [DATA_WIDTH-1:0] bMat  [MAX_DIM][MAX_DIM];
    logic [BUS_WIDTH-1:0]  spMem [SP_NTARGETS][MAX_DIM][MAX_DIM];

    logic [DATA_WIDTH-1:0] busElem [MAX_DIM];
    logic [DIM_W-1:0]      nextRow;
    logic [DIM_W-1:0]      nextCol;
    logic [BUS_WIDTH-1:0]  dotSum;
    logic [BUS_WIDTH-1:0]  biasVal;
    logic [BUS_WIDTH-1:0]  nextData;
    logic                  nextOvf;
    logic                  lastElem;
    logic                  rowFire;

    assign rowFire = row_valid_i && row_ready_o;

    always_comb begin
        for (int e = 0; e < MAX_DIM; e++) begin
            busElem[e] = row_data_i[e*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Index of the element to register next. Outside CALC this is (0,0),
    // which is what gets registered on the final B row handshake.
    always_comb begin
        nextRow = '0;
        nextCol = '0;
        if (state == CALC) begin
            if (c_col_o == mDim) begin
                nextRow = c_row_o + DIM_W'(1);
            end else begin
                nextRow = c_row_o;
                nextCol = c_col_o + DIM_W'(1);
            end
        end
    end

    always_comb begin
        logic signed [DATA_WIDTH-1:0]   aElem;
        logic signed [DATA_WIDTH-1:0]   bElem;
        logic signed [2*DATA_WIDTH-1:0] prod;
        aElem  = '0;
        bElem  = '0;
        prod   = '0;
        dotSum = '0;
        for (int k = 0; k < MAX_DIM; k++) begin
            aElem = aMat[nextRow][k];
            // Element (0,0) is computed while the last B row is still on the bus.
            if (state == LOAD_B && DIM_W'(k) == rowIdx) begin
                bElem = busElem[nextCol];
            end else begin
                bElem = bMat[k][nextCol];
            end
            prod = (2*DATA_WIDTH)'(aElem) * (2*DATA_WIDTH)'(bElem);
            if (k <= int'(kDim)) begin
                dotSum = dotSum + BUS_WIDTH'(prod);
            end
        end
    end

    always_comb begin
        biasVal  = biasEn ? spMem[spSel][nextRow][nextCol] : '0;
        nextData = dotSum + biasVal;
        // Signed overflow: both addends share a sign that the sum lacks.
        nextOvf  = biasEn
                && (dotSum[BUS_WIDTH-1] == biasVal[BUS_WIDTH-1])
                && (nextData[BUS_WIDTH-1] != dotSum[BUS_WIDTH-1]);
        lastElem = (c_row_o == nDim) && (c_col_o == mDim);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            c_valid_o   <= 1'b0;
            row_ready_o <= 1'b0;
            ovf_o       <= 1'b0;
            c_data_o    <= '0;
            c_row_o     <= '0;
            c_col_o     <= '0;
            rowIdx      <= '0;
            nDim        <= '0;
            kDim        <= '0;
            mDim        <= '0;
            biasEn      <= 1'b0;
            spSel       <= '0;
            for (int s = 0; s < SP_NTARGETS; s++) begin
                for (int i = 0; i < MAX_DIM; i++) begin
                    for (int j = 0; j < MAX_DIM; j++) begin
                        spMem[s][i][j] <= '0;
                    end
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        nDim        <= n_dim_i;
                        kDim        <= k_dim_i;
                        mDim        <= m_dim_i;
                        biasEn      <= bias_i;
                        spSel       <= sp_sel_i;
                        ovf_o       <= 1'b0;
                        rowIdx      <= '0;
                        busy_o      <= 1'b1;
                        row_ready_o <= 1'b1;
                        state       <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (rowFire) begin
                        for (int e = 0; e < MAX_DIM; e++) begin
                            aMat[rowIdx][e] <= busElem[e];
                        end
                        if (rowIdx == nDim) begin
                            rowIdx <= '0;
                            state  <= LOAD_B;
                        end else begin
                            rowIdx <= rowIdx + DIM_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (rowFire) begin
                        for (int e = 0; e < MAX_DIM; e++) begin
                            bMat[rowIdx][e] <= busElem[e];
                        end
                        if (rowIdx == kDim) begin
                            row_ready_o <= 1'b0;
                            c_valid_o   <= 1'b1;
                            c_data_o    <= nextData;
                            c_row_o     <= '0;
                            c_col_o     <= '0;
                            ovf_o       <= ovf_o | nextOvf;
                            state       <= CALC;
                        end else begin
                            rowIdx <= rowIdx + DIM_W'(1);
                        end
                    end
                end
                CALC: begin
                    if (c_ready_i) begin
                        spMem[spSel][c_row_o][c_col_o] <= c_data_o;
                        if (lastElem) begin
                            c_valid_o <= 1'b0;
                            done_o    <= 1'b1;
                            state     <= DONE;
                        end else begin
                            c_data_o <= nextData;
                            c_row_o  <= nextRow;
                            c_col_o  <= nextCol;
                            ovf_o    <= ovf_o | nextOvf;
                        end
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
